adder_result_checker: RTL and testbench

//  Scoreboard/response end of the ripple-carry adder datapath. The stimulus side drives ain/bin/cin

---
 rtl/adder_chk_pkg.sv | 24 ++
 rtl/adder_chk_delay_line.sv | 50 +++++
 rtl/adder_result_checker.sv | 124 ++++++++++++
 tb/tb_adder_result_checker.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types, error-kind indices and helpers for the adder result checker.
// Included by adder_chk_delay_line and adder_result_checker (optional feature: ADDER_CHK_CHAIN_EN).
package adder_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_t;

    // Bit positions in the per-cycle error-kind vector
    localparam int ERR_MISMATCH = 0;
    localparam int ERR_MISSING  = 1;
    localparam int ERR_SPURIOUS = 2;
    localparam int ERR_CHAIN    = 3;
    localparam int ERR_KINDS    = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/adder_chk_delay_line.sv
// LATENCY-stage valid+data shift register aligning golden results with the DUT pipeline.
// LATENCY=0 is a wire; rst/clear empty the line by dropping every valid bit.
module adder_chk_delay_line
    import adder_chk_pkg::*;
#(
    parameter int LATENCY = 0,
    parameter int DATA_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (LATENCY == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, clear};
            assign out_valid   = in_valid;
            assign out_data    = in_data;
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_q;
            logic [DATA_W-1:0]  data_q [LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else if (clear) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= in_valid;
                    for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            // NOTE: the data stages carry no reset; the valid bit qualifies every stage, so resetting them adds nothing.
            always_ff @(posedge clk) begin
                data_q[0] <= in_data;
                for (int i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
            end

            assign out_valid = vld_q[LATENCY-1];
            assign out_data  = data_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/adder_result_checker.sv
// Response checker for the ripple-carry adder: golden {carry,sum}, aligned compare, counters, first failure.
// Define ADDER_CHK_CHAIN_EN to add the dut_c port and check the internal carry chain as well.
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int LATENCY = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             dut_valid,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_carry,
`ifdef ADDER_CHK_CHAIN_EN
    input  logic [WIDTH:0]   dut_c,
`endif
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [1:0]       state,
    output logic [WIDTH:0]   first_exp,
    output logic [WIDTH:0]   first_got
);

`ifdef ADDER_CHK_CHAIN_EN
    localparam int DATA_W = 3*WIDTH + 2;
`else
    localparam int DATA_W = WIDTH + 1;
`endif

    logic [WIDTH:0]         exp_sum, exp_d, got;
    logic [DATA_W-1:0]      data_in, data_d;
    logic                   dv, chain_bad, active, err;
    logic [ERR_KINDS-1:0]   err_vec;
    chk_state_t             cur_state;

    assign exp_sum = {1'b0, ain} + {1'b0, bin} + (WIDTH+1)'(cin);
    assign got     = {dut_carry, dut_sum};

`ifdef ADDER_CHK_CHAIN_EN
    logic [WIDTH-1:0] a_d, b_d;
    logic             cin_d;

    assign data_in = {ain, bin, cin, exp_sum};
    assign {a_d, b_d, cin_d, exp_d} = data_d;

    // Every link of the chain must equal the majority of its operand bits and the carry below it.
    always_comb begin
        chain_bad = (dut_c[0] != cin_d);
        for (int i = 0; i < WIDTH; i++) begin
            if (dut_c[i+1] != ((a_d[i] & b_d[i]) | (a_d[i] & dut_c[i]) | (b_d[i] & dut_c[i])))
                chain_bad = 1'b1;
        end
    end
`else
    assign data_in   = exp_sum;
    assign exp_d     = data_d;
    assign chain_bad = 1'b0;
`endif

    adder_chk_delay_line #(
        .LATENCY (LATENCY),
        .DATA_W  (DATA_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (data_in),
        .out_valid (dv),
        .out_data  (data_d)
    );

    always_comb begin
        err_vec               = '0;
        err_vec[ERR_MISMATCH] = dv & dut_valid & (got != exp_d);
        err_vec[ERR_MISSING]  = dv & ~dut_valid;
        err_vec[ERR_SPURIOUS] = ~dv & dut_valid;
        err_vec[ERR_CHAIN]    = dv & dut_valid & chain_bad;
    end

    assign active = dv | dut_valid;
    assign err    = |err_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_count <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
            cur_state <= ST_IDLE;
            first_exp <= '0;
            first_got <= '0;
        end else if (clear) begin
            chk_count <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
            cur_state <= ST_IDLE;
            first_exp <= '0;
            first_got <= '0;
        end else if (active) begin
            chk_count <= CNT_W'(sat_inc(32'(chk_count), CNT_W));
            if (err) begin
                err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
                err_flag  <= 1'b1;
                if (cur_state != ST_FAIL) begin
                    cur_state <= ST_FAIL;
                    first_exp <= err_vec[ERR_SPURIOUS] ? '0 : exp_d;
                    first_got <= err_vec[ERR_MISSING]  ? '0 : got;
                end
            end else if (cur_state == ST_IDLE) begin
                cur_state <= ST_RUN;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: a LATENCY=0/CNT_W=16 and a LATENCY=3/CNT_W=4 instance against a scoreboard model.
// Build with ADDER_CHK_CHAIN_EN defined to exercise the carry-chain check as well.
module tb_adder_result_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=24, LATENCY=0, CNT_W=16
    logic        c0_clear, c0_in_valid, c0_cin, c0_dut_valid, c0_dut_carry;
    logic [23:0] c0_ain, c0_bin, c0_dut_sum;
    logic [15:0] c0_chk, c0_err;
    logic        c0_flag;
    logic [1:0]  c0_state;
    logic [24:0] c0_fexp, c0_fgot;
    // Instance 3: WIDTH=24, LATENCY=3, CNT_W=4
    logic        c3_clear, c3_in_valid, c3_cin, c3_dut_valid, c3_dut_carry;
    logic [23:0] c3_ain, c3_bin, c3_dut_sum;
    logic [3:0]  c3_chk, c3_err;
    logic        c3_flag;
    logic [1:0]  c3_state;
    logic [24:0] c3_fexp, c3_fgot;
`ifdef ADDER_CHK_CHAIN_EN
    logic [24:0] c0_dut_c, c3_dut_c;
`endif

    adder_result_checker #(.WIDTH(24), .LATENCY(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .clear(c0_clear), .in_valid(c0_in_valid),
        .ain(c0_ain), .bin(c0_bin), .cin(c0_cin),
        .dut_valid(c0_dut_valid), .dut_sum(c0_dut_sum), .dut_carry(c0_dut_carry),
`ifdef ADDER_CHK_CHAIN_EN
        .dut_c(c0_dut_c),
`endif
        .chk_count(c0_chk), .err_count(c0_err), .err_flag(c0_flag), .state(c0_state),
        .first_exp(c0_fexp), .first_got(c0_fgot)
    );

    adder_result_checker #(.WIDTH(24), .LATENCY(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .clear(c3_clear), .in_valid(c3_in_valid),
        .ain(c3_ain), .bin(c3_bin), .cin(c3_cin),
        .dut_valid(c3_dut_valid), .dut_sum(c3_dut_sum), .dut_carry(c3_dut_carry),
`ifdef ADDER_CHK_CHAIN_EN
        .dut_c(c3_dut_c),
`endif
        .chk_count(c3_chk), .err_count(c3_err), .err_flag(c3_flag), .state(c3_state),
        .first_exp(c3_fexp), .first_got(c3_fgot)
    );

    typedef struct {
        int          chk;
        int          err;
        bit          flag;
        int          st;
        logic [24:0] fexp;
        logic [24:0] fgot;
    } model_t;

    typedef struct {
        bit          v;
        logic [23:0] a;
        logic [23:0] b;
        bit          c;
    } vec_t;

    model_t m0, m3;
    vec_t   pipe3[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic logic [24:0] golden(logic [23:0] a, logic [23:0] b, bit c);
        return 25'(a) + 25'(b) + 25'(c);
    endfunction

    // Carry into bit i is the overflow of adding the low i bits of both operands plus cin.
    function automatic logic [24:0] chain_of(logic [23:0] a, logic [23:0] b, bit c);
        logic [24:0]     ch;
        longint unsigned msk, s;
        for (int i = 0; i <= 24; i++) begin
            msk   = (64'd1 << i) - 64'd1;
            s     = (longint'(a) & msk) + (longint'(b) & msk) + longint'(c);
            ch[i] = s[i];
        end
        return ch;
    endfunction

    // One compare cycle of the scoreboard: what the checker outputs must read after this edge.
    function automatic model_t model_step(model_t m, bit clr, bit dv, logic [24:0] e,
                                          bit dval, logic [24:0] got, bit cbad, int cmax);
        model_t r;
        bit     bad;
        r = m;
        if (clr) begin
            r = '{default: 0};
        end else if (dv || dval) begin
            bad   = (dv != dval) || (dv && (got != e || cbad));
            r.chk = (m.chk < cmax) ? m.chk + 1 : cmax;
            if (bad) begin
                r.err  = (m.err < cmax) ? m.err + 1 : cmax;
                r.flag = 1'b1;
                if (m.st != 2) begin
                    r.st   = 2;
                    r.fexp = dv   ? e   : 25'd0;
                    r.fgot = dval ? got : 25'd0;
                end
            end else if (m.st == 0) begin
                r.st = 1;
            end
        end
        return r;
    endfunction

    function automatic logic [84:0] pk(model_t m);
        return {16'(m.chk), 16'(m.err), m.flag, 2'(m.st), m.fexp, m.fgot};
    endfunction

    function automatic logic [84:0] snap0();
        return {c0_chk, c0_err, c0_flag, c0_state, c0_fexp, c0_fgot};
    endfunction

    function automatic logic [84:0] snap3();
        return {12'd0, c3_chk, 12'd0, c3_err, c3_flag, c3_state, c3_fexp, c3_fgot};
    endfunction

    task automatic step0(input bit clr, input bit v, input logic [23:0] a, input logic [23:0] b,
                         input bit c, input bit dval, input logic [24:0] got, input logic [24:0] dc);
        bit cbad;
        @(negedge clk);
        c0_clear = clr; c0_in_valid = v; c0_ain = a; c0_bin = b; c0_cin = c;
        c0_dut_valid = dval; {c0_dut_carry, c0_dut_sum} = got;
`ifdef ADDER_CHK_CHAIN_EN
        c0_dut_c = dc;
`endif
        cbad = v && dval && (dc != chain_of(a, b, c));
        m0 = model_step(m0, clr, v, golden(a, b, c), dval, got, cbad, 65535);
        @(posedge clk);
        #1;
    endtask

    // The LATENCY=3 adder is modelled by pipe3: its result emerges three cycles after issue.
    task automatic step3(input bit clr, input bit v, input logic [23:0] a, input logic [23:0] b,
                         input bit c, input bit drop, input bit extra, input logic [24:0] xval);
        vec_t        f;
        bit          dval;
        logic [24:0] e, got;
        @(negedge clk);
        pipe3.push_back('{v, a, b, c});
        f    = pipe3.pop_front();
        e    = golden(f.a, f.b, f.c);
        dval = drop ? 1'b0 : (f.v | extra);
        got  = f.v ? e : xval;
        c3_clear = clr; c3_in_valid = v; c3_ain = a; c3_bin = b; c3_cin = c;
        c3_dut_valid = dval; {c3_dut_carry, c3_dut_sum} = got;
`ifdef ADDER_CHK_CHAIN_EN
        c3_dut_c = chain_of(f.a, f.b, f.c);
`endif
        m3 = model_step(m3, clr, f.v, e, dval, got, 1'b0, 15);
        if (clr) begin
            pipe3.delete();
            repeat (3) pipe3.push_back('{0, 0, 0, 0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c0_clear = 0; c0_in_valid = 0; c0_ain = 0; c0_bin = 0; c0_cin = 0;
        c0_dut_valid = 0; c0_dut_sum = 0; c0_dut_carry = 0;
        c3_clear = 0; c3_in_valid = 0; c3_ain = 0; c3_bin = 0; c3_cin = 0;
        c3_dut_valid = 0; c3_dut_sum = 0; c3_dut_carry = 0;
`ifdef ADDER_CHK_CHAIN_EN
        c0_dut_c = 0; c3_dut_c = 0;
`endif
        m0 = '{default: 0};
        m3 = '{default: 0};
        pipe3.delete();
        repeat (3) pipe3.push_back('{0, 0, 0, 0});
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (snap0() !== 85'd0) begin
            n_bad++; $display("FAIL reset0: got %h expected 0", snap0());
        end
        n_cmp++;
        if (snap3() !== 85'd0) begin
            n_bad++; $display("FAIL reset3: got %h expected 0", snap3());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_counting();
        logic [23:0] a, b;
        bit          c;
        step0(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            a = 24'(i / 20); b = 24'(i / 10); c = bit'((i / 5) % 2);
            step0(0, 1, a, b, c, 1, golden(a, b, c), chain_of(a, b, c));
        end
        n_cmp++;
        if (c0_chk !== 16'd64 || c0_err !== 16'd0 || c0_state !== 2'd1) begin
            n_bad++; $display("FAIL counting: chk %0d err %0d state %0d, expected 64 0 1", c0_chk, c0_err, c0_state);
        end
        n_cmp++;
        if (snap0() !== pk(m0)) begin
            n_bad++; $display("FAIL counting_model: got %h expected %h", snap0(), pk(m0));
        end
    endtask

    task automatic test_wrap();
        step0(0, 1, 24'hFFFFFF, 24'h000001, 0, 1, 25'h1000000, chain_of(24'hFFFFFF, 24'h000001, 0));
        n_cmp++;
        if (c0_err !== 16'd0 || c0_state !== 2'd1 || c0_chk !== 16'd65) begin
            n_bad++; $display("FAIL wrap: chk %0d err %0d state %0d, expected 65 0 1", c0_chk, c0_err, c0_state);
        end
        step0(0, 1, 24'hFFFFFF, 24'hFFFFFF, 1, 1, 25'h1FFFFFF, chain_of(24'hFFFFFF, 24'hFFFFFF, 1));
        n_cmp++;
        if (c0_err !== 16'd0 || c0_chk !== 16'd66) begin
            n_bad++; $display("FAIL wrap_cin: chk %0d err %0d, expected 66 0", c0_chk, c0_err);
        end
    endtask

    task automatic test_mismatch();
        logic [24:0] g;
        step0(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            g = golden(24'(i), 24'(i), 0);
            if (i == 4) g[0] = ~g[0];
            step0(0, 1, 24'(i), 24'(i), 0, 1, g, chain_of(24'(i), 24'(i), 0));
        end
        n_cmp++;
        if (c0_state !== 2'd2 || c0_flag !== 1'b1 || c0_err !== 16'd1 ||
            c0_fexp !== 25'h8 || c0_fgot !== 25'h9) begin
            n_bad++; $display("FAIL mismatch: state %0d flag %0d err %0d exp %h got %h, expected 2 1 1 008 009",
                              c0_state, c0_flag, c0_err, c0_fexp, c0_fgot);
        end
        n_cmp++;
        if (snap0() !== pk(m0)) begin
            n_bad++; $display("FAIL mismatch_model: got %h expected %h", snap0(), pk(m0));
        end
    endtask

    task automatic test_latency();
        logic [23:0] a [10];
        logic [23:0] b [10];
        step3(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            a[k] = 24'($urandom); b[k] = 24'($urandom);
        end
        for (int k = 0; k < 16; k++) begin
            if (k < 10) step3(0, 1, a[k], b[k], k[0], k == 6, 0, 0);
            else        step3(0, 0, 0, 0, 0, 0, k == 15, 25'h0ABCDE);
            if (k == 12) begin
                n_cmp++;
                if (c3_err !== 4'd1 || c3_state !== 2'd2 || c3_fgot !== 25'd0 ||
                    c3_fexp !== golden(a[3], b[3], 1'b1)) begin
                    n_bad++; $display("FAIL missing: err %0d state %0d exp %h got %h, expected 1 2 %h 0",
                                      c3_err, c3_state, c3_fexp, c3_fgot, golden(a[3], b[3], 1'b1));
                end
            end
        end
        n_cmp++;
        if (c3_err !== 4'd2 || c3_chk !== 4'd11) begin
            n_bad++; $display("FAIL spurious: err %0d chk %0d, expected 2 11", c3_err, c3_chk);
        end
        n_cmp++;
        if (snap3() !== pk(m3)) begin
            n_bad++; $display("FAIL latency_model: got %h expected %h", snap3(), pk(m3));
        end
    endtask

    task automatic test_saturation();
        step3(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step3(0, 0, 0, 0, 0, 0, 1, 25'(k));
        n_cmp++;
        if (c3_err !== 4'd15 || c3_chk !== 4'd15 || c3_state !== 2'd2) begin
            n_bad++; $display("FAIL saturate: err %0d chk %0d state %0d, expected 15 15 2", c3_err, c3_chk, c3_state);
        end
        step3(0, 1, 24'h111111, 24'h222222, 0, 0, 0, 0);
        step3(0, 1, 24'h333333, 24'h444444, 1, 0, 0, 0);
        step3(1, 1, 24'h555555, 24'h666666, 0, 0, 0, 0);
        n_cmp++;
        if (snap3() !== 85'd0) begin
            n_bad++; $display("FAIL clear: got %h expected 0", snap3());
        end
        repeat (5) step3(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (c3_chk !== 4'd0 || c3_err !== 4'd0 || c3_state !== 2'd0) begin
            n_bad++; $display("FAIL flushed: chk %0d err %0d state %0d, expected 0 0 0", c3_chk, c3_err, c3_state);
        end
        for (int k = 0; k < 8; k++) step3(0, 1, 24'($urandom), 24'($urandom), bit'($urandom), 0, 0, 0);
        repeat (3) step3(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (c3_chk !== 4'd8 || c3_err !== 4'd0 || c3_state !== 2'd1) begin
            n_bad++; $display("FAIL back_to_back: chk %0d err %0d state %0d, expected 8 0 1", c3_chk, c3_err, c3_state);
        end
    endtask

    task automatic test_random();
        logic [23:0] a, b;
        logic [24:0] g;
        bit          c, v, dval;
        int unsigned f;
        step0(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            a = 24'($urandom); b = 24'($urandom); c = bit'($urandom);
            v = ($urandom_range(3, 0) != 0);
            f = $urandom_range(31, 0);
            g = golden(a, b, c);
            dval = v;
            if (f == 0 && v) g = g ^ (25'd1 << $urandom_range(24, 0));
            if (f == 1 && v) dval = 1'b0;
            if (f == 2 && !v) begin dval = 1'b1; g = 25'($urandom); end
            step0(0, v, a, b, c, dval, g, chain_of(a, b, c));
            n_cmp++;
            if (snap0() !== pk(m0)) begin
                n_bad++; $display("FAIL random[%0d]: got %h expected %h", k, snap0(), pk(m0));
            end
        end
    endtask

`ifdef ADDER_CHK_CHAIN_EN
    task automatic test_chain();
        logic [24:0] dc;
        step0(1, 0, 0, 0, 0, 0, 0, 0);
        step0(0, 1, 24'h1F, 24'h1F, 0, 1, 25'h3E, chain_of(24'h1F, 24'h1F, 0));
        n_cmp++;
        if (c0_err !== 16'd0 || c0_state !== 2'd1) begin
            n_bad++; $display("FAIL chain_ok: err %0d state %0d, expected 0 1", c0_err, c0_state);
        end
        dc = chain_of(24'h1F, 24'h1F, 0);
        dc[5] = 1'b0;
        step0(0, 1, 24'h1F, 24'h1F, 0, 1, 25'h3E, dc);
        n_cmp++;
        if (c0_err !== 16'd1 || c0_state !== 2'd2 || c0_fexp !== 25'h3E || c0_fgot !== 25'h3E) begin
            n_bad++; $display("FAIL chain_stuck: err %0d state %0d exp %h got %h, expected 1 2 03e 03e",
                              c0_err, c0_state, c0_fexp, c0_fgot);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_counting();
        test_wrap();
        test_mismatch();
        test_latency();
        test_saturation();
        test_random();
`ifdef ADDER_CHK_CHAIN_EN
        test_chain();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
